// File: rtl/platform_scheduler.sv
// Owns the platform table: per-frame scroll, recycle of off-screen slots and landing test,
// plus the live per-pixel platform_on feed for the colour mapper.
module platform_scheduler #(
  parameter int N_PLAT      = 8,
  parameter int PLAT_HALF_W = 16,
  parameter int PLAT_HALF_H = 4,
  parameter int SCROLL_LINE = 200,
  parameter int SCREEN_H    = 480
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       game_en,
  input  logic       restart,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [9:0] Ball_size,
  input  logic       ball_falling,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       platform_on,
  output logic [9:0] scroll_amt,
  output logic       land,
  output logic [3:0] land_idx,
  output logic       busy
);
  localparam int AW = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SCROLL  = 2'd1;
  localparam logic [1:0] S_COLLIDE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [3:0]  LAST_IDX  = 4'(N_PLAT - 1);

  function automatic logic [9:0] rst_x(input int i);
    return 10'(64 + 64 * i);
  endfunction

  function automatic logic [9:0] rst_y(input int i);
    return 10'(30 + 60 * i);
  endfunction

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  x_q [N_PLAT];
  logic [9:0]  x_d [N_PLAT];
  logic [9:0]  y_q [N_PLAT];
  logic [9:0]  y_d [N_PLAT];
  logic [15:0] lfsr_q, lfsr_d;
  logic        frame_clk_q;
  logic [9:0]  bx_q, bx_d, by_q, by_d, bs_q, bs_d;
  logic        bf_q, bf_d;
  logic [9:0]  scroll_q, scroll_d;
  logic        land_q, land_d;
  logic [3:0]  land_idx_q, land_idx_d;
  logic        busy_q, busy_d;
  logic        hit_q, hit_d;
  logic [3:0]  hit_idx_q, hit_idx_d;

  logic          tick_s;
  logic [AW-1:0] idx_s;
  logic [9:0]    xs_s, ys_s, adx_s, scroll_tick_s;
  logic [10:0]   yn_s, ywrap_s;
  logic [11:0]   lim_s, foot_s;
  logic          hit_now_s, on_s;

  assign tick_s        = frame_clk & ~frame_clk_q;
  assign idx_s         = idx_q[AW-1:0];
  assign scroll_tick_s = (BallY < 10'(SCROLL_LINE)) ? (10'(SCROLL_LINE) - BallY) : 10'd0;

  // Per-slot datapath shared by the scroll and collide passes
  always_comb begin
    xs_s    = x_q[idx_s];
    ys_s    = y_q[idx_s];
    yn_s    = {1'b0, ys_s} + {1'b0, scroll_q};
    ywrap_s = yn_s - 11'(SCREEN_H);
    adx_s   = absdiff(bx_q, xs_s);
    lim_s   = 12'(PLAT_HALF_W) + {2'b00, bs_q};
    foot_s  = {2'b00, by_q} + {2'b00, bs_q};
    // Range test is rearranged so nothing goes negative near the top of the screen
    hit_now_s = bf_q
              & ({2'b00, adx_s} <= lim_s)
              & ((foot_s + 12'(PLAT_HALF_H)) >= {2'b00, ys_s})
              & (foot_s <= ({2'b00, ys_s} + 12'(PLAT_HALF_H)));
  end

  // Live pixel hit against every slot
  always_comb begin
    on_s = 1'b0;
    for (int i = 0; i < N_PLAT; i++) begin
      if ((absdiff(DrawX, x_q[i]) <= 10'(PLAT_HALF_W)) &&
          (absdiff(DrawY, y_q[i]) <= 10'(PLAT_HALF_H))) begin
        on_s = 1'b1;
      end else begin
        on_s = on_s;
      end
    end
  end

  // Update sequencer: IDLE -> SCROLL (N cycles) -> COLLIDE (N cycles) -> DONE
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    x_d        = x_q;
    y_d        = y_q;
    lfsr_d     = lfsr_q;
    bx_d       = bx_q;
    by_d       = by_q;
    bs_d       = bs_q;
    bf_d       = bf_q;
    scroll_d   = scroll_q;
    land_d     = 1'b0;
    land_idx_d = land_idx_q;
    busy_d     = busy_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    case (state_q)
      S_IDLE: begin
        if (restart) begin
          for (int i = 0; i < N_PLAT; i++) begin
            x_d[i] = rst_x(i);
            y_d[i] = rst_y(i);
          end
          lfsr_d     = LFSR_SEED;
          scroll_d   = 10'd0;
          land_idx_d = 4'd0;
        end else if (tick_s && game_en) begin
          bx_d      = BallX;
          by_d      = BallY;
          bs_d      = Ball_size;
          bf_d      = ball_falling;
          scroll_d  = scroll_tick_s;
          idx_d     = 4'd0;
          hit_d     = 1'b0;
          hit_idx_d = 4'd0;
          busy_d    = 1'b1;
          state_d   = S_SCROLL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCROLL: begin
        if (yn_s >= 11'(SCREEN_H)) begin
          y_d[idx_s] = ywrap_s[9:0];
          x_d[idx_s] = 10'(PLAT_HALF_W) + {1'b0, lfsr_q[8:0]};
          lfsr_d     = lfsr_next(lfsr_q);
        end else begin
          y_d[idx_s] = yn_s[9:0];
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = S_COLLIDE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_COLLIDE: begin
        if (hit_now_s && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
        end else begin
          hit_d = hit_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          idx_d      = 4'd0;
          land_d     = hit_q | hit_now_s;
          land_idx_d = hit_q ? hit_idx_q : (hit_now_s ? idx_q : 4'd0);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and table registers; reset restores the power-on layout
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      for (int i = 0; i < N_PLAT; i++) begin
        x_q[i] <= rst_x(i);
        y_q[i] <= rst_y(i);
      end
      lfsr_q      <= LFSR_SEED;
      frame_clk_q <= 1'b0;
      bx_q        <= 10'd0;
      by_q        <= 10'd0;
      bs_q        <= 10'd0;
      bf_q        <= 1'b0;
      scroll_q    <= 10'd0;
      land_q      <= 1'b0;
      land_idx_q  <= 4'd0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      hit_idx_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lfsr_q      <= lfsr_d;
      frame_clk_q <= frame_clk;
      bx_q        <= bx_d;
      by_q        <= by_d;
      bs_q        <= bs_d;
      bf_q        <= bf_d;
      scroll_q    <= scroll_d;
      land_q      <= land_d;
      land_idx_q  <= land_idx_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign platform_on = on_s;
  assign scroll_amt  = scroll_q;
  assign land        = land_q;
  assign land_idx    = land_idx_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_platform_scheduler.sv
// Randomized scoreboard bench for platform_scheduler against a slot-list reference model.
module tb_platform_scheduler;
  localparam int N  = 8;
  localparam int HW = 16;
  localparam int HH = 4;
  localparam int SL = 200;
  localparam int SH = 480;

  logic       Clk, Reset_n, frame_clk, game_en, restart, ball_falling;
  logic [9:0] BallX, BallY, Ball_size, DrawX, DrawY;
  logic       platform_on, land, busy;
  logic [9:0] scroll_amt;
  logic [3:0] land_idx;

  platform_scheduler #(.N_PLAT(N), .PLAT_HALF_W(HW), .PLAT_HALF_H(HH),
                       .SCROLL_LINE(SL), .SCREEN_H(SH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .game_en(game_en),
    .restart(restart), .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size),
    .ball_falling(ball_falling), .DrawX(DrawX), .DrawY(DrawY),
    .platform_on(platform_on), .scroll_amt(scroll_amt), .land(land),
    .land_idx(land_idx), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { int t; int sc; int ld; int li; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_until = -100;
  int mx[N];
  int my[N];
  int mlfsr;

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int lfsr_step(input int s);
    logic [15:0] v;
    v = s[15:0];
    return int'({16'd0, v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 64 + 64 * i;
      my[i] = 30 + 60 * i;
    end
    mlfsr = 'hACE1;
  endtask

  task automatic model_update(input int bx, input int by, input int bs, input int bf,
                              output int sc, output int ld, output int li);
    sc = (by < SL) ? SL - by : 0;
    for (int i = 0; i < N; i++) begin
      if (my[i] + sc >= SH) begin
        my[i] = my[i] + sc - SH;
        mx[i] = HW + (mlfsr & 511);
        mlfsr = lfsr_step(mlfsr);
      end else begin
        my[i] = my[i] + sc;
      end
    end
    ld = 0;
    li = 0;
    for (int i = 0; i < N; i++) begin
      if (ld == 0 && bf != 0 && iabs(bx - mx[i]) <= HW + bs &&
          by + bs >= my[i] - HH && by + bs <= my[i] + HH) begin
        ld = 1;
        li = i;
      end
    end
  endtask

  function automatic int model_on(input int px, input int py);
    int r = 0;
    for (int i = 0; i < N; i++)
      if (iabs(px - mx[i]) <= HW && iabs(py - my[i]) <= HH) r = 1;
    return r;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic probe(input string nm, input int px, input int py, input int exp);
    DrawX = 10'(px);
    DrawY = 10'(py);
    #1;
    chk(nm, int'(platform_on), exp);
  endtask

  task automatic check_table();
    int px[4];
    int py[4];
    for (int i = 0; i < N; i++) begin
      px = '{mx[i], mx[i] + HW, mx[i] + HW + 1, mx[i]};
      py = '{my[i], my[i] + HH, my[i], my[i] - HH - 1};
      for (int j = 0; j < 4; j++)
        if (py[j] >= 0 && px[j] < 1024) probe("platform_on", px[j], py[j], model_on(px[j], py[j]));
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && cyc <= busy_until + 1; k++) step();
  endtask

  task automatic do_tick(input int bx, input int by, input int bs, input int bf, input bit rs);
    exp_t e;
    bit rs_acc;
    rs_acc = 1'b0;
    step();
    BallX = 10'(bx);
    BallY = 10'(by);
    Ball_size = 10'(bs);
    ball_falling = 1'(bf);
    frame_clk = 1'b1;
    restart = rs;
    if (cyc > busy_until) begin
      if (rs) begin
        model_reset();
        rs_acc = 1'b1;
      end else if (game_en) begin
        model_update(bx, by, bs, bf, e.sc, e.ld, e.li);
        e.t = cyc;
        sb.push_back(e);
        busy_until = cyc + 2 * N + 1;
      end
    end
    step();
    frame_clk = 1'b0;
    restart = 1'b0;
    BallX = 10'($urandom_range(0, 1023));
    BallY = 10'($urandom_range(0, 1023));
    Ball_size = 10'($urandom_range(0, 1023));
    ball_falling = 1'($urandom_range(0, 1));
    if (rs_acc) chk("restart_tick_scroll", int'(scroll_amt), 0);
    step();
  endtask

  task automatic do_restart();
    bit acc;
    step();
    restart = 1'b1;
    acc = (cyc > busy_until);
    if (acc) model_reset();
    step();
    restart = 1'b0;
    if (acc) begin
      chk("restart_scroll", int'(scroll_amt), 0);
      chk("restart_land", int'(land), 0);
    end
  endtask

  // Monitor: pairs each observed update with the oldest expected one
  initial begin
    exp_t cur;
    bit in_upd = 1'b0;
    bit busy_prev = 1'b0;
    int land_cyc = -1;
    int land_idx_seen = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        sb.delete();
        in_upd = 1'b0;
        busy_prev = 1'b0;
        land_cyc = -1;
      end else begin
        if (busy && !busy_prev) begin
          chk("update_expected", int'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            cur = sb.pop_front();
            in_upd = 1'b1;
            land_cyc = -1;
            chk("busy_rise_cycle", cyc, cur.t + 1);
          end
        end
        if (land) begin
          chk("land_in_update", int'(in_upd && land_cyc == -1), 1);
          land_cyc = cyc;
          land_idx_seen = int'(land_idx);
        end
        if (!busy && busy_prev && in_upd) begin
          in_upd = 1'b0;
          chk("busy_fall_cycle", cyc, cur.t + 2 * N + 2);
          chk("scroll_amt", int'(scroll_amt), cur.sc);
          if (cur.ld != 0) begin
            chk("land_cycle", land_cyc, cur.t + 2 * N + 1);
            chk("land_idx", land_idx_seen, cur.li);
          end else begin
            chk("no_land", land_cyc, -1);
          end
        end
        busy_prev = busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; game_en = 1'b0; restart = 1'b0;
    BallX = 10'd0; BallY = 10'd0; Ball_size = 10'd0; ball_falling = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0;
    model_reset();
    step(); step();
    Reset_n = 1'b1;
    step();
    chk("reset_busy", int'(busy), 0);
    chk("reset_land", int'(land), 0);
    chk("reset_scroll", int'(scroll_amt), 0);
    probe("reset_on_64_30", 64, 30, 1);
    probe("reset_on_512_450", 512, 450, 1);
    probe("reset_off_64_40", 64, 40, 0);
    check_table();

    // Scroll by 50: slot 7 wraps to y=20 at the seed's x
    game_en = 1'b1;
    do_tick(300, 150, 4, 0, 1'b0);
    wait_idle();
    probe("recycled_241_20", 241, 20, 1);
    probe("slot0_64_80", 64, 80, 1);
    check_table();

    // Landing on slot 3 with no scroll, then not falling plus a dropped second tick
    do_restart();
    do_tick(256, 202, 4, 1, 1'b0);
    wait_idle();
    do_tick(256, 202, 4, 0, 1'b0);
    step(); step(); step();
    do_tick(64, 100, 4, 1, 1'b0);
    wait_idle();
    check_table();

    // game_en drop mid-update, then a tick with game_en low
    do_tick(400, 120, 6, 1, 1'b0);
    step();
    game_en = 1'b0;
    wait_idle();
    do_tick(400, 120, 6, 1, 1'b0);
    step(); step();
    chk("disabled_tick_busy", int'(busy), 0);
    game_en = 1'b1;

    // Restart while busy is ignored; restart with tick wins
    do_tick(200, 170, 5, 1, 1'b0);
    do_restart();
    wait_idle();
    check_table();
    do_tick(200, 100, 5, 1, 1'b1);
    wait_idle();
    chk("restart_wins_busy", int'(busy), 0);
    check_table();

    // Async reset in the middle of SCROLL
    do_tick(100, 120, 4, 1, 1'b0);
    step();
    chk("mid_update_busy", int'(busy), 1);
    Reset_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_land", int'(land), 0);
    chk("async_scroll", int'(scroll_amt), 0);
    model_reset();
    busy_until = -100;
    probe("async_on_64_30", 64, 30, 1);
    step();
    Reset_n = 1'b1;
    step();
    check_table();

    for (int it = 0; it < 60; it++) begin
      int j;
      int bs;
      int bx;
      int by;
      int bf;
      game_en = 1'($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) do_restart();
      j = int'($urandom_range(0, N - 1));
      bs = int'($urandom_range(1, 12));
      if ($urandom_range(0, 1) == 1) begin
        bx = mx[j] + int'($urandom_range(0, 60)) - 30;
        by = my[j] - bs + int'($urandom_range(0, 10)) - 5;
      end else begin
        bx = int'($urandom_range(0, 639));
        by = int'($urandom_range(0, 479));
      end
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      bf = int'($urandom_range(0, 3) != 0);
      do_tick(bx, by, bs, bf, 1'b0);
      wait_idle();
      check_table();
    end

    wait_idle();
    repeat (5) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
